// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared types and width helpers for the ring-oscillator PUF
// response generator.
//   state_t - measurement sequencer states
//   idx_w   - bits needed to index N oscillators
//   k_w     - bits needed for the response bit index
//   tie_w   - bits needed to count 0..RESP_BITS ties
//   IDX_W / TIE_W - widths for the default configuration (8 ROs, 4 bits)
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    MEASURE = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int N_RO_DEF      = 8;
  localparam int RESP_BITS_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int k_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic int tie_w(input int r);
    return $clog2(r) + 1;
  endfunction

  localparam int IDX_W = idx_w(N_RO_DEF);
  localparam int TIE_W = tie_w(RESP_BITS_DEF);

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: counts rising edges of one asynchronous oscillator signal.
//   clk  - system clock
//   rst  - synchronous active-high reset (clears synchroniser and counter)
//   ro   - raw oscillator output, asynchronous to clk
//   clr  - synchronous counter/flag clear
//   en   - count enable; detected edges outside en are dropped
//   cnt  - saturating edge count
//   sat  - set once cnt has reached its maximum since the last clear
// The input passes a 2-flop synchroniser; a third flop provides the previous
// sample for rising-edge detection, so an edge is counted two to three clk
// cycles after it occurs.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             sync1_r;
  logic             sync2_r;
  logic             sync3_r;
  logic             edge_s;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  assign edge_s = sync2_r & ~sync3_r;

  // Synchroniser chain plus edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= ro;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Saturating edge counter; sat marks the step that lands on CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (en && edge_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
      sat_r <= sat_r | (cnt_r == (CNT_MAX - CNT_W'(1)));
    end else begin
      cnt_r <= cnt_r;
      sat_r <= sat_r;
    end
  end

  assign cnt = cnt_r;
  assign sat = sat_r;

endmodule

// File: rtl/ro_puf_resp_gen.sv
// ro_puf_resp_gen: ring-oscillator PUF response generator.
// For each response bit k, enables oscillator pair a=(chal+2k), b=a+1
// (wrapping modulo N_RO), counts their rising edges over a window of W clk
// cycles and sets resp[k] when a ran faster than b.
//   clk        - system clock
//   rst_n      - synchronous reset, ACTIVE-HIGH despite its name
//   ro_in      - raw oscillator outputs (asynchronous)
//   ro_en      - oscillator gate enables (two bits set in CLEAR/MEASURE)
//   start      - begin measurement (only honoured in IDLE)
//   chal       - challenge base index, latched on start
//   win_len    - window length in clk cycles, 0 behaves as 1
//   busy       - sequencer not in IDLE
//   resp       - response word, meaningful while resp_valid
//   resp_valid - response available (DONE state)
//   resp_ready - consumer accepts the response
//   tie_cnt    - number of pairs that produced equal counts
//   sat        - any counter saturated during this response
// All outputs are registered from the next-state decode, so they line up
// with the state they describe.
module ro_puf_resp_gen
  import ro_puf_pkg::*;
#(
  parameter int N_RO      = N_RO_DEF,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter int RESP_BITS = RESP_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_RO-1:0]                  ro_in,
  output logic [N_RO-1:0]                  ro_en,
  input  logic                             start,
  input  logic [idx_w(N_RO)-1:0]           chal,
  input  logic [WIN_W-1:0]                 win_len,
  output logic                             busy,
  output logic [RESP_BITS-1:0]             resp,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [tie_w(RESP_BITS)-1:0]      tie_cnt,
  output logic                             sat
);

  localparam int IW = idx_w(N_RO);
  localparam int KW = k_w(RESP_BITS);
  localparam int TW = tie_w(RESP_BITS);
  localparam logic [KW-1:0]   K_LAST  = KW'(RESP_BITS - 1);
  localparam logic [N_RO-1:0] ONE_HOT = {{(N_RO-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               next_state_s;
  logic [IW-1:0]        chal_r;
  logic [IW-1:0]        chal_nxt_s;
  logic [KW-1:0]        k_r;
  logic [KW-1:0]        k_nxt_s;
  logic [WIN_W-1:0]     win_r;
  logic [WIN_W-1:0]     wcnt_r;
  logic [RESP_BITS-1:0] resp_r;
  logic [TW-1:0]        tie_r;
  logic                 sat_r;
  logic                 busy_r;
  logic                 valid_r;
  logic [N_RO-1:0]      ro_en_r;
  logic [IW-1:0]        a_cur_s;
  logic [IW-1:0]        b_cur_s;
  logic [IW-1:0]        a_nxt_s;
  logic [IW-1:0]        b_nxt_s;
  logic [N_RO-1:0]      mask_nxt_s;
  logic [CNT_W-1:0]     cnt_a_s;
  logic [CNT_W-1:0]     cnt_b_s;
  logic                 sat_a_s;
  logic                 sat_b_s;
  logic                 cnt_clr_s;
  logic                 cnt_en_s;

  // Pair being measured now (drives the counter muxes).
  assign a_cur_s = chal_r + IW'({k_r, 1'b0});
  assign b_cur_s = a_cur_s + IW'(1);

  assign cnt_clr_s = (state_r == CLEAR);
  assign cnt_en_s  = (state_r == MEASURE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst_n),
    .ro  (ro_in[a_cur_s]),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_a_s),
    .sat (sat_a_s)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst_n),
    .ro  (ro_in[b_cur_s]),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_b_s),
    .sat (sat_b_s)
  );

  // Next-state, next bit index/challenge and the enable mask they imply.
  always_comb begin
    next_state_s = state_r;
    k_nxt_s      = k_r;
    chal_nxt_s   = chal_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CLEAR;
          k_nxt_s      = {KW{1'b0}};
          chal_nxt_s   = chal;
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        next_state_s = MEASURE;
      end
      MEASURE: begin
        // Window counter holds the cycles left including this one.
        if (wcnt_r <= WIN_W'(1)) begin
          next_state_s = COMPARE;
        end else begin
          next_state_s = MEASURE;
        end
      end
      COMPARE: begin
        if (k_r == K_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CLEAR;
          k_nxt_s      = k_r + KW'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    a_nxt_s    = chal_nxt_s + IW'({k_nxt_s, 1'b0});
    b_nxt_s    = a_nxt_s + IW'(1);
    mask_nxt_s = (ONE_HOT << a_nxt_s) | (ONE_HOT << b_nxt_s);
  end

  // Sequencer state, registered outputs and response accumulation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= IDLE;
      chal_r  <= {IW{1'b0}};
      k_r     <= {KW{1'b0}};
      win_r   <= {WIN_W{1'b0}};
      wcnt_r  <= {WIN_W{1'b0}};
      resp_r  <= {RESP_BITS{1'b0}};
      tie_r   <= {TW{1'b0}};
      sat_r   <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      ro_en_r <= {N_RO{1'b0}};
    end else begin
      state_r <= next_state_s;
      chal_r  <= chal_nxt_s;
      k_r     <= k_nxt_s;
      busy_r  <= (next_state_s != IDLE);
      valid_r <= (next_state_s == DONE);
      ro_en_r <= ((next_state_s == CLEAR) || (next_state_s == MEASURE)) ?
                 mask_nxt_s : {N_RO{1'b0}};
      case (state_r)
        IDLE: begin
          if (start) begin
            win_r  <= (win_len == {WIN_W{1'b0}}) ? WIN_W'(1) : win_len;
            resp_r <= {RESP_BITS{1'b0}};
            tie_r  <= {TW{1'b0}};
            sat_r  <= 1'b0;
          end
        end
        CLEAR: begin
          wcnt_r <= win_r;
        end
        MEASURE: begin
          wcnt_r <= wcnt_r - WIN_W'(1);
        end
        COMPARE: begin
          resp_r[k_r] <= (cnt_a_s > cnt_b_s);
          if (cnt_a_s == cnt_b_s) begin
            tie_r <= tie_r + TW'(1);
          end
          sat_r <= sat_r | sat_a_s | sat_b_s;
        end
        default: begin
          wcnt_r <= wcnt_r;
        end
      endcase
    end
  end

  assign ro_en      = ro_en_r;
  assign busy       = busy_r;
  assign resp       = resp_r;
  assign resp_valid = valid_r;
  assign tie_cnt    = tie_r;
  assign sat        = sat_r;

endmodule

// File: tb/tb_ro_puf_resp_gen.sv
// Self-checking bench for ro_puf_resp_gen. Oscillators are modelled as gated
// rings: held low while disabled, and when enabled they go high on the first
// falling clk edge and repeat with period per[i] clk cycles. With that model
// the number of rises a W-cycle window observes is (W-2)/P+1 for W>=2 and 0
// otherwise, which the reference model uses directly.
module tb_ro_puf_resp_gen;
  import ro_puf_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [7:0]         ro_in;
  logic [7:0]         ro_en;
  logic               start;
  logic [IDX_W-1:0]   chal;
  logic [15:0]        win_len;
  logic               busy;
  logic [3:0]         resp;
  logic               resp_valid;
  logic               resp_ready;
  logic [TIE_W-1:0]   tie_cnt;
  logic               sat;

  logic [3:0]  ro_in2;
  logic [3:0]  ro_en2;
  logic        start2;
  logic [1:0]  chal2;
  logic [15:0] win_len2;
  logic        busy2;
  logic [0:0]  resp2;
  logic        resp_valid2;
  logic        resp_ready2;
  logic [0:0]  tie_cnt2;
  logic        sat2;

  int per [0:11];
  int ph  [0:11];
  int checks = 0;
  int errors = 0;

  ro_puf_resp_gen dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en), .start(start),
    .chal(chal), .win_len(win_len), .busy(busy), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .tie_cnt(tie_cnt),
    .sat(sat)
  );

  ro_puf_resp_gen #(.N_RO(4), .CNT_W(3), .WIN_W(16), .RESP_BITS(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in2), .ro_en(ro_en2), .start(start2),
    .chal(chal2), .win_len(win_len2), .busy(busy2), .resp(resp2),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .tie_cnt(tie_cnt2),
    .sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gated oscillator models, advanced on the falling clk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!ro_en[i]) begin
        ph[i] = 0;
        ro_in[i] = 1'b0;
      end else begin
        ro_in[i] = (ph[i] < per[i] / 2);
        ph[i] = (ph[i] + 1) % per[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!ro_en2[i]) begin
        ph[8 + i] = 0;
        ro_in2[i] = 1'b0;
      end else begin
        ro_in2[i] = (ph[8 + i] < per[8 + i] / 2);
        ph[8 + i] = (ph[8 + i] + 1) % per[8 + i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int p, input int w);
    return (w < 2) ? 0 : (w - 2) / p + 1;
  endfunction

  // Reference: pair k uses (c+2k, c+2k+1) mod 8; faster oscillator wins.
  function automatic void model(input int c, input int w, output logic [3:0] r,
                                output int t);
    int weff;
    int ca;
    int cb;
    weff = (w == 0) ? 1 : w;
    r = 4'b0000;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      ca = exp_cnt(per[(c + 2 * k) % 8], weff);
      cb = exp_cnt(per[(c + 2 * k + 1) % 8], weff);
      r[k] = (ca > cb);
      if (ca == cb) t++;
    end
  endfunction

  // One full challenge on the main DUT, optionally stalling in DONE.
  task automatic run_main(input int c, input int w, input int hold);
    logic [3:0] er;
    int et;
    int n;
    int weff;
    int lim;
    logic [7:0] m;
    logic [3:0] held;
    weff = (w == 0) ? 1 : w;
    model(c, w, er, et);
    @(negedge clk);
    chal = IDX_W'(c);
    win_len = 16'(w);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    m = 8'd0;
    m[c % 8] = 1'b1;
    m[(c + 1) % 8] = 1'b1;
    chk("ro_en_first_pair", 32'(ro_en), 32'(m));
    chk("busy_running", 32'(busy), 32'd1);
    lim = 4 * (weff + 2) + 40;
    while (!resp_valid && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(4 * (weff + 2) + 1));
    chk("resp", 32'(resp), 32'(er));
    chk("tie_cnt", 32'(tie_cnt), 32'(et));
    chk("sat", 32'(sat), 32'd0);
    chk("ro_en_done", 32'(ro_en), 32'd0);
    held = resp;
    for (int h = 0; h < hold; h++) begin
      start = (h % 2 == 0);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp", 32'(resp), 32'(held));
      chk("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("release_valid", 32'(resp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] r;
    int n;
    rst_n = 1'b1;
    start = 1'b0;
    chal = '0;
    win_len = 16'd0;
    resp_ready = 1'b0;
    start2 = 1'b0;
    chal2 = 2'd0;
    win_len2 = 16'd0;
    resp_ready2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      per[i] = 8;
      ph[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_tie", 32'(tie_cnt), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Directed: known periods, chal 0, window 24, stall 20 cycles in DONE.
    per[0] = 4; per[1] = 6; per[2] = 6; per[3] = 4;
    per[4] = 8; per[5] = 8; per[6] = 4; per[7] = 8;
    model(0, 24, r, n);
    chk("model_sanity_resp", 32'(r), 32'b1001);
    run_main(0, 24, 20);

    // Wrapping pair (7,0) and the minimum window.
    run_main(7, 24, 0);
    for (int i = 0; i < 8; i++) per[i] = 8;
    run_main(3, 0, 0);
    run_main(5, 1, 0);
    run_main(2, 2, 0);

    // Reset in the middle of MEASURE, then a fresh full-length run.
    per[0] = 4; per[1] = 6; per[2] = 6; per[3] = 4;
    per[4] = 8; per[5] = 8; per[6] = 4; per[7] = 8;
    @(negedge clk);
    chal = IDX_W'(0);
    win_len = 16'd24;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ro_en", 32'(ro_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_tie", 32'(tie_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    run_main(0, 24, 0);

    // Randomized periods, challenges and windows.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) per[i] = int'($urandom_range(12, 4));
      run_main(int'($urandom_range(7, 0)), int'($urandom_range(40, 0)), 3);
    end

    // Saturation on a 3-bit counter: 16 rises vs 4 rises over 64 cycles.
    per[8] = 4;
    per[9] = 16;
    @(negedge clk);
    chal2 = 2'd0;
    win_len2 = 16'd64;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    chk("sat_ro_en", 32'(ro_en2), 32'h3);
    n = 1;
    while (!resp_valid2 && n < 120) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sat_latency", 32'(n), 32'd67);
    chk("sat_resp", 32'(resp2), 32'd1);
    chk("sat_tie", 32'(tie_cnt2), 32'd0);
    chk("sat_flag", 32'(sat2), 32'd1);
    resp_ready2 = 1'b1;
    @(posedge clk);
    #1;
    resp_ready2 = 1'b0;
    chk("sat_release", 32'(resp_valid2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_resp_gen.md
Name: ro_puf_resp_gen

Overview:
- Parametrised ring-oscillator PUF response generator.
- Enables one oscillator pair at a time and counts rising edges of each over a programmable clock window. Compares the two counts to produce one response bit per pair, and accumulates RESP_BITS bits into a response word delivered over a valid/ready handshake.
- Sits between the free-running oscillator array and the top-level I/O.
- Replaces the fixed 16:1 mux / single-counter / compare arrangement with synchronised, windowed, multi-bit measurement.

Parameters:
- N_RO, 8, number of oscillators, power of two, at least 4.
- CNT_W, 16, edge-counter width.
- WIN_W, 16, width of the window-length input.
- RESP_BITS, 4, response bits per challenge, at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-high (asserted = 1 resets on the next clk edge).
- ro_in  in  N_RO  raw oscillator outputs, asynchronous to clk.
- ro_en  out  N_RO  per-oscillator enable, drives the oscillator gate.
- start  in  1  begin a measurement; sampled only in IDLE.
- chal  in  log2(N_RO)  challenge base index, latched on accepted start.
- win_len  in  WIN_W  measurement window in clk cycles, latched on start; 0 treated as 1.
- busy  out  1  high in any state other than IDLE.
- resp  out  RESP_BITS  response word; valid only while resp_valid is high.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- tie_cnt  out  log2(RESP_BITS)+1  number of pairs with equal counts in the current response.
- sat  out  1  any counter saturated during the current response.

Behaviour:
- Reset values: ro_en=0, busy=0, resp=0, resp_valid=0, tie_cnt=0, sat=0, state IDLE, counters 0. Reset mid-operation aborts immediately with the same values; synchroniser flops are also cleared.
- Pair selection for bit k (0..RESP_BITS-1):
  - a = (chal + 2k) mod N_RO
  - b = (chal + 2k + 1) mod N_RO
  - mod is natural wrap in log2(N_RO) bits.
- Edge path per channel: 2-flop synchroniser, then a rising-edge detect (sync2 & ~sync3). Correct counts require oscillator frequency below clk/4.
- FSM states:
  - IDLE: busy=0. On start=1, latch chal and win_len, clear resp, tie_cnt and sat, set k=0, then go to CLEAR.
  - CLEAR (1 cycle): zero both counters, set ro_en bits a and b, load window counter W=max(win_len,1), then go to MEASURE.
  - MEASURE (exactly W cycles): each counter increments on its detected edge. Counters saturate at 2^CNT_W-1 and set sat. The window counter decrements each cycle; when it reaches 1, go to COMPARE.
  - COMPARE (1 cycle):
    - ro_en=0.
    - resp[k] = 1 if cnt_a > cnt_b, else 0.
    - If cnt_a == cnt_b, increment tie_cnt (resp[k]=0).
    - If k == RESP_BITS-1, go to DONE; otherwise k++ and go to CLEAR.
  - DONE: resp_valid=1, resp and flags held stable. On resp_ready=1, go to IDLE next cycle with resp_valid=0. start is ignored in DONE.
- Edges arriving in CLEAR or COMPARE are not counted.
- Latency: start accepted at cycle 0; resp_valid rises at cycle RESP_BITS*(W+2)+1.
- ro_en is only ever non-zero in CLEAR and MEASURE, with exactly two bits set.
- start held high continuously re-triggers only from IDLE. resp_ready asserted outside DONE has no effect.

Decomposition:
- Package ro_puf_pkg:
  - state enum {IDLE, CLEAR, MEASURE, COMPARE, DONE}
  - width helper constants IDX_W=log2(N_RO) and TIE_W.
- One sub-module: ro_edge_counter (synchroniser, edge detect, saturating CNT_W counter with clear and count-enable, sat flag). Two instances, fed by muxed ro_in[a] and ro_in[b].
- FSM, pair indexing and response register stay in the top module.

Test Plan:
- Defaults, chal=0, win_len=24. ro0 period 4 clk, ro1 period 6; ro2/ro3 periods 6/4; ro4/ro5 both period 8; ro6/ro7 periods 4/8. Expect counts 6/4, 4/6, 3/3, 6/3 -> resp=4'b1001, tie_cnt=1, resp_valid at cycle 4*26+1=105.
- chal=7 -> pairs (7,0),(1,2),(3,4),(5,6). Check wrap on ro_en: bits 7 and 0 high in the first CLEAR/MEASURE.
- win_len=0 -> W=1, every pair reads 0/0 or at most 1 edge. With all periods 8: resp=0, tie_cnt=4, resp_valid at cycle 13.
- CNT_W=3, win_len=64, ro period 4 -> counter stops at 7, sat=1.
- Hold resp_ready=0 for 20 cycles in DONE: resp stable, busy=1, start pulses ignored. resp_ready=1 returns to IDLE next cycle.
- Assert rst_n=1 mid-MEASURE: next cycle ro_en=0, busy=0, resp_valid=0. A fresh start produces the full-length result.
